// File: rtl/alu_pkg.sv
// Shared ALU/sequencer types: opcode encoding, sequencer states and the instruction word layout.
package alu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OPC_W   = 3;
  localparam int unsigned REG_AW  = 2;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic [OPC_W-1:0] {
    ADD      = 3'd0,
    SUBTRACT = 3'd1,
    AND_OP   = 3'd2,
    OR_OP    = 3'd3,
    XOR_OP   = 3'd4,
    NOT_OP   = 3'd5,
    REG      = 3'd6,
    HALT_OP  = 3'd7
  } instruction_code;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    HALT = 2'd3
  } seq_state_t;

  typedef struct packed {
    instruction_code    opcode;
    logic [REG_AW-1:0]  rd;
    logic [REG_AW-1:0]  rs;
    logic               imm_sel;
    logic [DATA_W-1:0]  imm;
  } seq_instr_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two operand read ports, one debug read port, one synchronous write port.
module alu_regfile #(
  parameter int unsigned NREGS = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] ra_i,
  input  logic [$clog2(NREGS)-1:0] rb_i,
  input  logic [$clog2(NREGS)-1:0] rdbg_i,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] wa_i,
  input  logic [DW-1:0]            wd_i,
  output logic [DW-1:0]            ra_data_c,
  output logic [DW-1:0]            rb_data_c,
  output logic [DW-1:0]            dbg_data_c
);

  logic [DW-1:0] regs_q [NREGS];

  // Reset takes priority over a coincident write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_c  = regs_q[ra_i];
  assign rb_data_c  = regs_q[rb_i];
  assign dbg_data_c = regs_q[rdbg_i];

endmodule

// File: rtl/alu_sequencer.sv
// Three-cycle instruction sequencer feeding an external combinational ALU and writing results back.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned NREGS = 4,
  parameter int unsigned DW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [DW-1:0]      alu_i_1,
  output logic [DW-1:0]      alu_i_2,
  output logic [OPC_W-1:0]   alu_op_code,
  input  logic [DW-1:0]      alu_result,
  output logic               res_valid,
  output logic [DW-1:0]      res_data,
  output logic [REG_AW-1:0]  res_rd,
  output logic               zero,
  output logic               halted,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DW-1:0]      dbg_data
);

  seq_state_t        state_q, state_d;
  logic [DW-1:0]     a1_q, a1_d, a2_q, a2_d;
  instruction_code   op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DW-1:0]     res_data_q, res_data_d;
  logic [REG_AW-1:0] res_rd_q, res_rd_d;
  logic              zero_q, zero_d;
  logic              ready_q, valid_q, halted_q;

  seq_instr_t        instr_c;
  logic [DW-1:0]     ra_data_c, rb_data_c;
  logic              we_c;

  assign instr_c = seq_instr_t'(in_instr);
  assign we_c    = (state_q == EXEC);

  alu_regfile #(.NREGS(NREGS), .DW(DW)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .ra_i       (instr_c.rd),
    .rb_i       (instr_c.rs),
    .rdbg_i     (dbg_addr),
    .we_i       (we_c),
    .wa_i       (rd_q),
    .wd_i       (alu_result),
    .ra_data_c  (ra_data_c),
    .rb_data_c  (rb_data_c),
    .dbg_data_c (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a1_q       <= '0;
      a2_q       <= '0;
      op_q       <= ADD;
      rd_q       <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      zero_q     <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      zero_q     <= zero_d;
      // Status flags are registered from the next state so they align with it
      ready_q    <= (state_d == IDLE);
      valid_q    <= (state_d == WB);
      halted_q   <= (state_d == HALT);
    end
  end

  always_comb begin
    state_d    = state_q;
    a1_d       = a1_q;
    a2_d       = a2_q;
    op_d       = op_q;
    rd_d       = rd_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    zero_d     = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (instr_c.opcode == HALT_OP) begin
            state_d = HALT;
          end else begin
            a1_d    = ra_data_c;
            a2_d    = instr_c.imm_sel ? DW'(instr_c.imm) : rb_data_c;
            op_d    = instr_c.opcode;
            rd_d    = instr_c.rd;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        res_data_d = alu_result;
        res_rd_d   = rd_q;
        zero_d     = (alu_result == '0);
        state_d    = WB;
      end
      WB:      state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = ready_q;
  assign alu_i_1     = a1_q;
  assign alu_i_2     = a2_q;
  assign alu_op_code = op_q;
  assign res_valid   = valid_q;
  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;
  assign zero        = zero_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench: instruction-level register-file model, with a behavioural ALU closing the loop.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [7:0]  alu_i_1, alu_i_2;
  logic [2:0]  alu_op_code;
  logic [7:0]  alu_result;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [1:0]  res_rd;
  logic        zero;
  logic        halted;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] model_r [4];

  always #5 clk = ~clk;

  alu_sequencer #(.NREGS(4), .DW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .alu_i_1     (alu_i_1),
    .alu_i_2     (alu_i_2),
    .alu_op_code (alu_op_code),
    .alu_result  (alu_result),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .zero        (zero),
    .halted      (halted),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op_code, alu_i_1, alu_i_2);

  function automatic logic [15:0] mk(input int op, input int rd, input int rs, input int sel, input int imm);
    return {3'(op), 2'(rd), 2'(rs), 1'(sel), 8'(imm)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check_eq(tag, 32'(dbg_data), 32'(model_r[i]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model_r[i] = 8'h00;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where it is idle again
  task automatic run_instr(input logic [15:0] ins, input bit keep, input logic [15:0] nxt);
    int op, rd, rs, sel, imm;
    logic [7:0] a, b, exp;
    op  = int'(ins[15:13]);
    rd  = int'(ins[12:11]);
    rs  = int'(ins[10:9]);
    sel = int'(ins[8]);
    imm = int'(ins[7:0]);
    a   = model_r[rd];
    b   = (sel != 0) ? 8'(imm) : model_r[rs];
    exp = alu_f(3'(op), a, b);
    in_instr = ins;
    in_valid = 1'b1;
    dbg_addr = 2'(rd);
    check_eq("ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = keep;
    if (keep) in_instr = nxt;
    check_eq("ready_exec", 32'(in_ready), 32'd0);
    check_eq("valid_exec", 32'(res_valid), 32'd0);
    check_eq("alu_i_1", 32'(alu_i_1), 32'(a));
    check_eq("alu_i_2", 32'(alu_i_2), 32'(b));
    check_eq("alu_op", 32'(alu_op_code), 32'(op));
    @(negedge clk);
    model_r[rd] = exp;
    check_eq("valid_wb", 32'(res_valid), 32'd1);
    check_eq("ready_wb", 32'(in_ready), 32'd0);
    check_eq("res_data", 32'(res_data), 32'(exp));
    check_eq("res_rd", 32'(res_rd), 32'(rd));
    check_eq("zero", 32'(zero), 32'(exp == 8'h00));
    check_eq("dbg_wb", 32'(dbg_data), 32'(exp));
    check_eq("alu_hold", 32'(alu_i_1), 32'(a));
    @(negedge clk);
    check_eq("valid_idle", 32'(res_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] q [3];
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    dbg_addr = '0;
    @(negedge clk);
    do_reset();

    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_valid", 32'(res_valid), 32'd0);
    check_eq("rst_data", 32'(res_data), 32'd0);
    check_eq("rst_rd", 32'(res_rd), 32'd0);
    check_eq("rst_zero", 32'(zero), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_alu1", 32'(alu_i_1), 32'd0);
    check_eq("rst_alu2", 32'(alu_i_2), 32'd0);
    check_eq("rst_op", 32'(alu_op_code), 32'd0);
    check_regs("rst_reg");

    // Directed cases: load, wrap to zero, xor, not
    run_instr(mk(6, 1, 0, 1, 8'h5A), 1'b0, '0);
    run_instr(mk(6, 1, 0, 1, 8'hFF), 1'b0, '0);
    run_instr(mk(0, 1, 0, 1, 8'h01), 1'b0, '0);
    run_instr(mk(6, 2, 0, 1, 8'h0F), 1'b0, '0);
    run_instr(mk(6, 3, 0, 1, 8'hF0), 1'b0, '0);
    run_instr(mk(4, 2, 3, 0, 8'h00), 1'b0, '0);
    run_instr(mk(5, 2, 0, 0, 8'h00), 1'b0, '0);
    run_instr(mk(1, 3, 3, 0, 8'h00), 1'b0, '0);
    check_regs("dir_reg");

    // in_valid held high across three queued instructions
    q[0] = mk(6, 0, 0, 1, 8'h11);
    q[1] = mk(0, 0, 0, 0, 8'h00);
    q[2] = mk(3, 1, 0, 0, 8'h00);
    run_instr(q[0], 1'b1, q[1]);
    run_instr(q[1], 1'b1, q[2]);
    run_instr(q[2], 1'b0, '0);

    for (int n = 0; n < 80; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      run_instr(mk(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 255))), 1'b0, '0);
    end
    check_regs("rnd_reg");

    // Reset during EXEC abandons the instruction
    run_instr(mk(6, 0, 0, 1, 8'h33), 1'b0, '0);
    in_instr = mk(1, 0, 0, 1, 8'h01);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model_r[i] = 8'h00;
    check_eq("mid_rst_valid", 32'(res_valid), 32'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
    dbg_addr = 2'd0;
    #1;
    check_eq("mid_rst_r0", 32'(dbg_data), 32'd0);
    @(negedge clk);
    check_eq("mid_rst_nowb", 32'(res_valid), 32'd0);

    // HALT blocks further instructions until reset
    run_instr(mk(6, 2, 0, 1, 8'h77), 1'b0, '0);
    in_instr = mk(7, 0, 0, 0, 8'h00);
    in_valid = 1'b1;
    @(negedge clk);
    in_instr = mk(0, 2, 0, 1, 8'h01);
    for (int c = 0; c < 5; c++) begin
      check_eq("halt_flag", 32'(halted), 32'd1);
      check_eq("halt_ready", 32'(in_ready), 32'd0);
      check_eq("halt_valid", 32'(res_valid), 32'd0);
      check_eq("halt_op", 32'(alu_op_code), 32'd6);
      @(negedge clk);
    end
    check_regs("halt_reg");
    do_reset();
    check_eq("post_halt_flag", 32'(halted), 32'd0);
    check_eq("post_halt_ready", 32'(in_ready), 32'd1);
    check_regs("post_halt_reg");
    run_instr(mk(0, 3, 0, 1, 8'h00), 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction sequencer that sits directly upstream of the combinational `alu`. It accepts 16-bit instruction words over a valid/ready handshake and reads operands from a private 4×8 register file. It drives the ALU operand and opcode inputs from registers, then writes the ALU result back to the register file and reports it on a result port. One instruction completes every 3 cycles; opcode 7 halts the sequencer until reset.

## Interface
Parameters:
- `NREGS`, 4: register file depth; must be 4 (2-bit register fields).
- `DW`, 8: data width; must match the ALU width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: instruction word valid.
- `in_ready` out 1: sequencer can accept an instruction.
- `in_instr` in 16: instruction, laid out as follows:
  - [15:13] opcode
  - [12:11] rd
  - [10:9] rs
  - [8] imm_sel
  - [7:0] imm
- `alu_i_1` out 8: registered ALU operand 1.
- `alu_i_2` out 8: registered ALU operand 2.
- `alu_op_code` out 3: registered ALU opcode.
- `alu_result` in 8: ALU `o_main`.
- `res_valid` out 1: one-cycle pulse, result written.
- `res_data` out 8: written value.
- `res_rd` out 2: destination register of `res_data`.
- `zero` out 1: last written result was 0.
- `halted` out 1: HALT executed.
- `dbg_addr` in 2: debug read address.
- `dbg_data` out 8: combinational read of `R[dbg_addr]`.

## Operation
- Opcode encoding (alu_pkg):
  - ADD=0, SUBTRACT=1, AND_OP=2, OR_OP=3, XOR_OP=4, NOT_OP=5, REG=6, HALT_OP=7.
- Operand mapping:
  - `alu_i_1` = `R[rd]`.
  - `alu_i_2` = imm_sel ? imm : `R[rs]`.
  - NOT_OP ignores `alu_i_2`; REG copies `alu_i_2` into rd (move / load-immediate).
- FSM states: IDLE, EXEC, WB, HALT.
  - IDLE: `in_ready`=1. On `in_valid`: opcode≠7 → latch operands and opcode, go to EXEC; opcode=7 → HALT.
  - EXEC: `R[rd]` ← `alu_result`; `res_data`/`res_rd` ← `alu_result`/rd; `zero` ← (`alu_result`==0); go to WB.
  - WB: `res_valid`=1; go to IDLE.
  - HALT: `in_ready`=0, `halted`=1; left only by `rst`.
- `in_ready`=0 in EXEC, WB and HALT. An instruction presented while busy is held by the producer, not dropped.
- rd==rs is legal; both operands read the same pre-write value.
- Arithmetic wraps mod 256 inside the ALU. The sequencer does no width extension and no carry.
- Reset values:
  - State IDLE; all R[i]=0.
  - `alu_i_1`=`alu_i_2`=0, `alu_op_code`=0 (ADD).
  - `res_valid`=0, `res_data`=0, `res_rd`=0, `zero`=0, `halted`=0.
  - `in_ready`=1 in the first cycle after reset.
- Reset mid-instruction (EXEC or WB): the instruction is abandoned. If `rst` is high in EXEC, no register write occurs because reset has priority.

## Timing
- Handshake at edge N (IDLE, `in_valid`&&`in_ready`).
  - Cycle N+1 (EXEC): ALU inputs valid from registers; the ALU result settles combinationally.
  - Edge N+1: write-back.
  - Cycle N+2 (WB): `res_valid`=1, and `dbg_data` reflects the new value.
  - Cycle N+3: IDLE, `in_ready`=1.
- Latency from accept to `res_valid` is 2 cycles; throughput is 1 instruction per 3 cycles.
- Back-to-back dependent instructions need no forwarding, because a write always lands before the next operand read.
- `alu_*` outputs hold their last values outside EXEC.

## Structure
- alu_pkg gains:
  - `HALT_OP` constant (3'd7).
  - `seq_state_t` enum (IDLE, EXEC, WB, HALT).
  - `seq_instr_t` packed struct with fields opcode (`instruction_code`), rd, rs, imm_sel, imm.
- Sub-module `alu_regfile`:
  - 4×8, two combinational read ports plus the debug read port.
  - One synchronous write port; synchronous reset to 0.
- The ALU is instantiated alongside the sequencer at the next level up, not inside it.

## Test plan
- Reset, then REG rd=1 imm_sel=1 imm=0x5A → `res_valid` 2 cycles after accept, `res_data`=0x5A, `res_rd`=1, `zero`=0, R1=0x5A.
- R1=0xFF, ADD rd=1 imm=0x01 → `res_data`=0x00, `zero`=1 (wrap).
- R2=0x0F, R3=0xF0, XOR rd=2 rs=3 → 0xFF; NOT rd=2 → 0x00.
- `in_valid` held high with 3 queued instructions → accepts exactly 3 cycles apart; `in_ready` low in EXEC and WB.
- HALT_OP → `halted`=1, `in_ready`=0, no `res_valid`. A following ADD is not accepted; after `rst`, `halted`=0 and R0..R3=0.
- `rst` asserted in the EXEC cycle of SUBTRACT rd=0 → R0 stays 0, no `res_valid`, IDLE next cycle.
